// File: rtl/fetch_queue_if.sv
// Fetch queue bundle: bus burst request/response plus decode window.
// master = fetch queue, slave = bus and decoder side.
interface fetch_queue_if #(
  parameter int BEAT_BYTES   = 8,
  parameter int WINDOW_BYTES = 15
);
  localparam int CW = $clog2(WINDOW_BYTES + 1);

  logic                      req_cyc;
  logic [63:0]               req_addr;
  logic                      req_ack;
  logic                      resp_cyc;
  logic [8*BEAT_BYTES-1:0]   resp_data;
  logic                      win_valid;
  logic [8*WINDOW_BYTES-1:0] win_bytes;
  logic [63:0]               win_rip;
  logic [CW-1:0]             consume;

  modport master (
    output req_cyc, req_addr,
    input  req_ack, resp_cyc, resp_data,
    output win_valid, win_bytes, win_rip,
    input  consume
  );

  modport slave (
    input  req_cyc, req_addr,
    output req_ack, resp_cyc, resp_data,
    input  win_valid, win_bytes, win_rip,
    output consume
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: line bursts into a circular byte queue,
// sliding decode window, redirect with drain of in-flight bursts.
module fetch_queue #(
  parameter int BUF_BYTES    = 128,
  parameter int BEAT_BYTES   = 8,
  parameter int LINE_BYTES   = 64,
  parameter int WINDOW_BYTES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] entry,
  input  logic        redirect,
  input  logic [63:0] redirect_rip,
  output logic        idle,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(BUF_BYTES) + 1;
  localparam int AW = PW - 1;
  localparam int LB = $clog2(LINE_BYTES);
  localparam int NB = LINE_BYTES / BEAT_BYTES;
  localparam int BW = $clog2(NB) + 1;
  localparam int CW = $clog2(WINDOW_BYTES + 1);
  localparam logic [63:0] LMASK = ~64'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DRAIN} state_t;

  state_t state;
  state_t state_n;

  logic          req_cyc;
  logic [63:0]   req_addr;
  logic [63:0]   fetch_addr;
  logic [63:0]   win_rip;
  logic [LB-1:0] skip;
  logic [BW-1:0] beat_cnt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] occ;
  logic [PW-1:0] free;
  logic [7:0]    mem [BUF_BYTES];

  logic          fetching;
  logic          in_burst;
  logic          last;
  logic          burst_end;
  logic          wr;
  logic          first;
  logic          win_valid;
  logic [BW-1:0] skip_beat;
  logic [PW-1:0] skip_lo;
  logic [PW-1:0] consume_eff;
  logic [AW-1:0] wr_base;
  logic [AW-1:0] rd_base;
  logic [8*WINDOW_BYTES-1:0] window;

  assign occ       = fill_ptr - rd_ptr;
  assign free      = PW'(BUF_BYTES) - occ;
  assign win_valid = occ >= PW'(WINDOW_BYTES);
  assign skip_beat = BW'(skip / BEAT_BYTES);
  assign skip_lo   = PW'(skip % BEAT_BYTES);
  assign wr_base   = fill_ptr[AW-1:0];
  assign rd_base   = rd_ptr[AW-1:0];

  assign bus.req_cyc   = req_cyc;
  assign bus.req_addr  = req_addr;
  assign bus.win_valid = win_valid;
  assign bus.win_rip   = win_rip;
  assign bus.win_bytes = window;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req_cyc && bus.req_ack)
          state_n = redirect ? DRAIN : WAIT;
      end
      WAIT, ACTIVE: begin
        if (burst_end)         state_n = IDLE;
        else if (redirect)     state_n = DRAIN;
        else if (bus.resp_cyc) state_n = ACTIVE;
      end
      DRAIN: begin
        if (burst_end) state_n = IDLE;
      end
    endcase
  end

  // Beats wholly ahead of the start RIP are dropped; the first kept
  // beat also advances rd_ptr past its unaligned leading bytes.
  always_comb begin
    fetching    = (state == WAIT) || (state == ACTIVE);
    in_burst    = fetching || (state == DRAIN);
    last        = beat_cnt == BW'(NB - 1);
    burst_end   = in_burst && bus.resp_cyc && last;
    wr          = fetching && bus.resp_cyc && !redirect
                  && (beat_cnt >= skip_beat);
    first       = wr && (beat_cnt == skip_beat);
    consume_eff = (win_valid && !redirect) ? PW'(bus.consume) : '0;
    idle        = (state == IDLE) && !req_cyc && (occ == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_cyc    <= 1'b0;
      req_addr   <= '0;
      fetch_addr <= entry & LMASK;
      skip       <= entry[LB-1:0];
      beat_cnt   <= '0;
      rd_ptr     <= '0;
      fill_ptr   <= '0;
      win_rip    <= entry;
    end else begin
      if (state == IDLE) begin
        if (req_cyc) begin
          if (bus.req_ack || redirect) req_cyc <= 1'b0;
        end else if (!redirect && free >= PW'(LINE_BYTES)) begin
          req_cyc  <= 1'b1;
          req_addr <= fetch_addr;
        end
      end
      if (in_burst && bus.resp_cyc)
        beat_cnt <= last ? '0 : beat_cnt + BW'(1);
      if (redirect) begin
        fetch_addr <= redirect_rip & LMASK;
        skip       <= redirect_rip[LB-1:0];
        rd_ptr     <= '0;
        fill_ptr   <= '0;
        win_rip    <= redirect_rip;
      end else begin
        if (burst_end && fetching) begin
          fetch_addr <= fetch_addr + 64'(LINE_BYTES);
          skip       <= '0;
        end
        fill_ptr <= fill_ptr + (wr ? PW'(BEAT_BYTES) : '0);
        rd_ptr   <= rd_ptr + consume_eff + (first ? skip_lo : '0);
        win_rip  <= win_rip + 64'(consume_eff);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !reset)
      for (int i = 0; i < BEAT_BYTES; i++)
        mem[wr_base + AW'(i)] <= bus.resp_data[8*i +: 8];
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < WINDOW_BYTES; i++)
      window[8*i +: 8] = mem[rd_base + AW'(i)];
  end

  a_consume: assert property (@(posedge clk) disable iff (reset)
    (bus.consume <= CW'(WINDOW_BYTES)) && (bus.consume == '0 || win_valid))
    else $fatal(1, "fetch_queue: consume protocol error");

endmodule
